keypad_input_unit: RTL and testbench
====================================

# keypad_input_unit

Scans a 4x4 matrix keypad, debounces it, and answers the CPU's keypad-input request. When `data_mem` raises `input_enable`, the block collects decimal digits into a 32-bit value and signals `input_complete` on Enter. It also owns the user pause toggle `cpu_pause`. Both handshake outputs go to `hazard_unit`, and the value goes to `data_mem` and `vga_unit`.

## Interface
Parameters:
- `SCAN_CYCLES`, default 50000: clock cycles each row is driven before its columns are sampled; minimum 2.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-scan snapshots required before a snapshot is accepted as stable; minimum 1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `input_enable`  in  1  from data_mem; level-high while a keypad load waits in MEM.
- `col_in`  in  4  keypad columns, active-low, externally pulled up, already synchronised.
- `row_out`  out  4  keypad rows, one-hot-low.
- `input_complete`  out  1  to hazard_unit; single-cycle pulse when entry is finished.
- `cpu_pause`  out  1  to hazard_unit; level, toggled by the pause key.
- `input_value`  out  32  to data_mem and vga_unit; accumulated unsigned decimal value.
- `digit_count`  out  4  to vga_unit; number of digits entered, 0-8.

## Operation
- **Key map** (row r, col c; index k = 4r + c):
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: * 0 # D
  - Function keys: C = pause toggle, D = Enter, * = clear. A, B and # are ignored.
- **Scanner**
  - Row pointer advances 0→1→2→3→0 every `SCAN_CYCLES` cycles.
  - `row_out` = ~(1 << ptr).
  - On the last cycle of each row window, ~`col_in` is written into bits [4r+3:4r] of a 16-bit working snapshot.
  - After row 3 is sampled, the working snapshot is compared with the previous full snapshot. Equal → stability counter +1, saturating at `DEBOUNCE_SCANS`. Different → counter = 1.
  - When the counter reaches `DEBOUNCE_SCANS`, the snapshot becomes the stable snapshot.
- **Key event**
  - Exactly one key event is produced when the stable snapshot changes from all-zero to exactly one bit set.
  - Multi-key snapshots produce no event.
  - Another event requires the stable snapshot to return to all-zero first.
- **FSM** states IDLE, ENTRY, DONE:
  - IDLE:
    - C event toggles `cpu_pause`; all other keys are ignored.
    - `input_enable`=1 → ENTRY, with `input_value`=0 and `digit_count`=0.
    - If a C event and `input_enable` rise occur in the same cycle, the toggle applies and the state still moves to ENTRY.
  - ENTRY:
    - Digit event with `digit_count`<8 → `input_value` = `input_value`*10 + d (exact, since at most 99,999,999 is reachable) and `digit_count`+1.
    - Digit event with `digit_count`=8 → ignored.
    - * event → value and count cleared.
    - D event → pulse `input_complete` for exactly one cycle and go to DONE. D with 0 digits is legal and completes with value 0.
    - C event → ignored (`cpu_pause` frozen).
    - `input_enable` falling while in ENTRY → return to IDLE with no pulse, value held.
  - DONE:
    - `input_value` and `digit_count` held.
    - All keys ignored.
    - `input_enable`=0 → IDLE.
- `input_value` and `digit_count` are cleared only on entering ENTRY, on *, or on reset. They stay readable after completion.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - state IDLE, row pointer 0, `row_out`=4'b1110.
  - `input_complete`=0, `cpu_pause`=0, `input_value`=0, `digit_count`=0.
  - Snapshots, stability counter and release flag are cleared.
  - Reset mid-entry discards the partial value.
- All outputs are registered. hazard_unit samples on the falling edge, so each pulse is seen exactly once.
- Press-to-event latency is 1 to 2 full scans plus (`DEBOUNCE_SCANS`-1) scans, where one scan = 4·`SCAN_CYCLES`.
- FSM effect (value update, pulse, toggle) occurs on the rising edge after the event cycle.
- IDLE→ENTRY takes 1 cycle after `input_enable` is sampled high. Keys still held from before are not re-triggered until released.
- `input_complete` is never asserted twice for one Enter press and never asserted outside ENTRY.

## Test plan
- **Digit entry:** `SCAN_CYCLES`=4, `DEBOUNCE_SCANS`=2, raise `input_enable`, press/release 4, 2, D → `input_value`=42, `digit_count`=2, one `input_complete` pulse, state DONE until `input_enable` drops.
- **Overflow guard and clear:** nine presses of 9 → value 99,999,999, count 8 (9th ignored). Then * → value 0, count 0. Then 7, D → value 7.
- **Pause toggle:** C in IDLE → `cpu_pause` 0→1. C again → 1→0. C during ENTRY → no change.
- **Debounce:** `col_in` glitching every scan for 5 scans, then stable key 5 → exactly one digit event. Chord 1+2 held → no event.
- **Abort and re-entry:** `input_enable` drops mid-ENTRY with value 3 → IDLE, no pulse. Re-raising it clears the value to 0.
- **Reset mid-entry:** `rst_n`=0 for one cycle during ENTRY → all outputs at reset values, `row_out`=4'b1110.

Source files
------------

// File: rtl/keypad_input_unit.sv
// 4x4 matrix keypad scanner with full-scan debouncing and a small entry FSM
// that accumulates decimal digits for the CPU's keypad-load request.
module keypad_input_unit #(
  parameter int SCAN_CYCLES    = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        input_enable,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic        input_complete,
  output logic        cpu_pause,
  output logic [31:0] input_value,
  output logic [3:0]  digit_count
);

  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_SCANS);

  localparam logic [3:0] KEY_C    = 4'd11;
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd15;

  typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_e;

  logic [CW-1:0] cycCnt_q, cycCnt_d;
  logic [1:0]    rowPtr_q, rowPtr_d;
  logic [3:0]    rowOut_q, rowOut_d;
  logic [15:0]   workSnap_q, workSnap_d;
  logic [15:0]   prevSnap_q, prevSnap_d;
  logic [15:0]   stableSnap_q, stableSnap_d;
  logic [SW-1:0] stab_q, stab_d;
  logic          keyHeld_q, keyHeld_d;
  logic          keyEvent_q, keyEvent_d;
  logic [3:0]    keyIdx_q, keyIdx_d;
  logic [15:0]   fullSnap;

  state_e        state_q, state_d;
  logic [31:0]   value_q, value_d;
  logic [3:0]    count_q, count_d;
  logic          pause_q, pause_d;
  logic          complete_q, complete_d;
  logic          isDigit;
  logic [3:0]    digitVal;

  // A key event fires only when the stable snapshot leaves all-zero for a single key.
  always_comb begin
    cycCnt_d     = cycCnt_q;
    rowPtr_d     = rowPtr_q;
    rowOut_d     = rowOut_q;
    workSnap_d   = workSnap_q;
    prevSnap_d   = prevSnap_q;
    stableSnap_d = stableSnap_q;
    stab_d       = stab_q;
    keyHeld_d    = keyHeld_q;
    keyEvent_d   = 1'b0;
    keyIdx_d     = keyIdx_q;
    fullSnap     = workSnap_q;
    if (cycCnt_q != CYC_LAST) begin
      cycCnt_d = cycCnt_q + CW'(1);
    end else begin
      cycCnt_d = '0;
      rowPtr_d = rowPtr_q + 2'd1;
      rowOut_d = ~(4'b0001 << rowPtr_d);
      fullSnap[{rowPtr_q, 2'b00} +: 4] = ~col_in;
      workSnap_d = fullSnap;
      if (rowPtr_q == 2'd3) begin
        prevSnap_d = fullSnap;
        if (fullSnap == prevSnap_q)
          stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + SW'(1);
        else
          stab_d = SW'(1);
        if (stab_d == STAB_MAX) begin
          stableSnap_d = fullSnap;
          keyHeld_d    = (fullSnap != 16'd0);
          if (!keyHeld_q && fullSnap != 16'd0 &&
              (fullSnap & (fullSnap - 16'd1)) == 16'd0) begin
            keyEvent_d = 1'b1;
            for (int i = 0; i < 16; i++)
              if (fullSnap[i]) keyIdx_d = 4'(i);
          end
        end
      end
    end
  end

  always_comb begin
    isDigit  = 1'b1;
    digitVal = 4'd0;
    case (keyIdx_q)
      4'd0:    digitVal = 4'd1;
      4'd1:    digitVal = 4'd2;
      4'd2:    digitVal = 4'd3;
      4'd4:    digitVal = 4'd4;
      4'd5:    digitVal = 4'd5;
      4'd6:    digitVal = 4'd6;
      4'd8:    digitVal = 4'd7;
      4'd9:    digitVal = 4'd8;
      4'd10:   digitVal = 4'd9;
      4'd13:   digitVal = 4'd0;
      default: isDigit  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (input_enable) state_d = ENTRY;
      ENTRY: begin
        if (!input_enable)
          state_d = IDLE;
        else if (keyEvent_q && keyIdx_q == KEY_D)
          state_d = DONE;
      end
      DONE:    if (!input_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Entry is abandoned silently when input_enable drops, so key handling needs it high.
  always_comb begin
    value_d    = value_q;
    count_d    = count_q;
    pause_d    = pause_q;
    complete_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (keyEvent_q && keyIdx_q == KEY_C) pause_d = ~pause_q;
        if (input_enable) begin
          value_d = 32'd0;
          count_d = 4'd0;
        end
      end
      ENTRY: begin
        if (input_enable && keyEvent_q) begin
          if (isDigit) begin
            if (count_q < 4'd8) begin
              value_d = (value_q << 3) + (value_q << 1) + {28'd0, digitVal};
              count_d = count_q + 4'd1;
            end
          end else if (keyIdx_q == KEY_STAR) begin
            value_d = 32'd0;
            count_d = 4'd0;
          end else if (keyIdx_q == KEY_D) begin
            complete_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycCnt_q     <= '0;
      rowPtr_q     <= 2'd0;
      rowOut_q     <= 4'b1110;
      workSnap_q   <= 16'd0;
      prevSnap_q   <= 16'd0;
      stableSnap_q <= 16'd0;
      stab_q       <= '0;
      keyHeld_q    <= 1'b0;
      keyEvent_q   <= 1'b0;
      keyIdx_q     <= 4'd0;
      state_q      <= IDLE;
      value_q      <= 32'd0;
      count_q      <= 4'd0;
      pause_q      <= 1'b0;
      complete_q   <= 1'b0;
    end else begin
      cycCnt_q     <= cycCnt_d;
      rowPtr_q     <= rowPtr_d;
      rowOut_q     <= rowOut_d;
      workSnap_q   <= workSnap_d;
      prevSnap_q   <= prevSnap_d;
      stableSnap_q <= stableSnap_d;
      stab_q       <= stab_d;
      keyHeld_q    <= keyHeld_d;
      keyEvent_q   <= keyEvent_d;
      keyIdx_q     <= keyIdx_d;
      state_q      <= state_d;
      value_q      <= value_d;
      count_q      <= count_d;
      pause_q      <= pause_d;
      complete_q   <= complete_d;
    end
  end

  assign row_out        = rowOut_q;
  assign input_complete = complete_q;
  assign cpu_pause      = pause_q;
  assign input_value    = value_q;
  assign digit_count    = count_q;

endmodule

// File: tb/tb_keypad_input_unit.sv
// Bench for keypad_input_unit: a behavioural keypad matrix plus a scoreboard
// of expected Enter results checked whenever input_complete pulses.
module tb_keypad_input_unit;

  localparam int SC   = 4;
  localparam int DB   = 2;
  localparam int HOLD = 6 * 4 * SC;

  localparam int K1 = 0, K2 = 1, K3 = 2, K4 = 4, K5 = 5, K6 = 6, K7 = 8;
  localparam int K8 = 9, K9 = 10, KC = 11, KSTAR = 12, KD = 15;

  typedef struct {
    logic [31:0] value;
    logic [3:0]  count;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        input_enable;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic        input_complete;
  logic        cpu_pause;
  logic [31:0] input_value;
  logic [3:0]  digit_count;
  logic [15:0] keysDown;

  exp_t sbQueue[$];
  exp_t sbHead;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   pulsesSeen = 0;
  int   pulsesExpected = 0;

  keypad_input_unit #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .input_enable(input_enable), .col_in(col_in),
    .row_out(row_out), .input_complete(input_complete), .cpu_pause(cpu_pause),
    .input_value(input_value), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  // Pressed keys short the driven (low) row onto their column.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keysDown[4*r+c]) col_in[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && input_complete === 1'b1) begin
      pulsesSeen++;
      testsRun++;
      if (sbQueue.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpected_complete: pulse with value %0d count %0d, none expected",
                 input_value, digit_count);
      end else begin
        sbHead = sbQueue.pop_front();
        if (input_value !== sbHead.value || digit_count !== sbHead.count) begin
          testsFailed++;
          $display("[TB] FAIL complete_value: got value %0d count %0d, expected value %0d count %0d",
                   input_value, digit_count, sbHead.value, sbHead.count);
        end
      end
    end
  end

  task automatic pressMask(input logic [15:0] m);
    keysDown = m;
    repeat (HOLD) @(negedge clk);
    keysDown = 16'd0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic pressKey(input int k);
    pressMask(16'd1 << k);
  endtask

  task automatic pressEnter(input logic [31:0] v, input logic [3:0] n);
    exp_t e;
    e.value = v;
    e.count = n;
    sbQueue.push_back(e);
    pulsesExpected++;
    pressKey(KD);
    testsRun++;
    if (sbQueue.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL enter_pulse: %0d expected completions outstanding, expected 0", sbQueue.size());
      sbQueue.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    input_enable = 1'b0;
    keysDown = 16'd0;
    repeat (2) @(negedge clk);
    testsRun++;
    if ({row_out, input_complete, cpu_pause, input_value, digit_count} !==
        {4'b1110, 1'b0, 1'b0, 32'd0, 4'd0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: row %b cmp %b pause %b value %0d count %0d, expected 1110 0 0 0 0",
               row_out, input_complete, cpu_pause, input_value, digit_count);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    testsRun++;
    if (row_out !== 4'b1110) begin
      testsFailed++;
      $display("[TB] FAIL row0_window: row_out %b, expected 1110", row_out);
    end
    @(negedge clk);
    testsRun++;
    if (row_out !== 4'b1101) begin
      testsFailed++;
      $display("[TB] FAIL row1_advance: row_out %b, expected 1101", row_out);
    end
  endtask

  task automatic test_digit_entry();
    input_enable = 1'b1;
    repeat (2) @(negedge clk);
    pressKey(K4);
    testsRun++;
    if (input_value !== 32'd4 || digit_count !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL digit_4: value %0d count %0d, expected 4 1", input_value, digit_count);
    end
    pressKey(K2);
    testsRun++;
    if (input_value !== 32'd42 || digit_count !== 4'd2) begin
      testsFailed++;
      $display("[TB] FAIL digit_42: value %0d count %0d, expected 42 2", input_value, digit_count);
    end
    pressEnter(32'd42, 4'd2);
    pressKey(K5);
    pressKey(KD);
    testsRun++;
    if (input_value !== 32'd42 || digit_count !== 4'd2) begin
      testsFailed++;
      $display("[TB] FAIL done_hold: value %0d count %0d, expected 42 2", input_value, digit_count);
    end
    input_enable = 1'b0;
    repeat (4) @(negedge clk);
    testsRun++;
    if (input_value !== 32'd42) begin
      testsFailed++;
      $display("[TB] FAIL idle_hold: value %0d, expected 42", input_value);
    end
  endtask

  task automatic test_overflow_clear();
    input_enable = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++;
    if (input_value !== 32'd0 || digit_count !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL entry_clear: value %0d count %0d, expected 0 0", input_value, digit_count);
    end
    for (int i = 0; i < 9; i++) pressKey(K9);
    testsRun++;
    if (input_value !== 32'd99999999 || digit_count !== 4'd8) begin
      testsFailed++;
      $display("[TB] FAIL overflow_guard: value %0d count %0d, expected 99999999 8",
               input_value, digit_count);
    end
    pressKey(KSTAR);
    testsRun++;
    if (input_value !== 32'd0 || digit_count !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL star_clear: value %0d count %0d, expected 0 0", input_value, digit_count);
    end
    pressKey(K7);
    pressEnter(32'd7, 4'd1);
    input_enable = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_pause();
    logic expPause;
    expPause = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pressKey(KC);
      expPause = ~expPause;
      testsRun++;
      if (cpu_pause !== expPause) begin
        testsFailed++;
        $display("[TB] FAIL pause_toggle_%0d: cpu_pause %b, expected %b", i, cpu_pause, expPause);
      end
    end
    input_enable = 1'b1;
    repeat (2) @(negedge clk);
    pressKey(KC);
    pressKey(K1);
    testsRun++;
    if (cpu_pause !== 1'b0 || input_value !== 32'd1 || digit_count !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL pause_frozen: pause %b value %0d count %0d, expected 0 1 1",
               cpu_pause, input_value, digit_count);
    end
    input_enable = 1'b0;
    repeat (4) @(negedge clk);
    pressKey(KC);
    testsRun++;
    if (cpu_pause !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pause_after_entry: cpu_pause %b, expected 1", cpu_pause);
    end
  endtask

  task automatic test_debounce();
    int guard;
    input_enable = 1'b1;
    repeat (2) @(negedge clk);
    guard = 0;
    while (row_out !== 4'b0111 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    while (row_out !== 4'b1110 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    testsRun++;
    if (guard >= 100) begin
      testsFailed++;
      $display("[TB] FAIL scan_sync: waited %0d cycles for row 0, expected under 100", guard);
    end
    for (int i = 0; i < 6; i++) begin
      keysDown = (i % 2 == 1) ? (16'd1 << K5) : 16'd0;
      repeat (4 * SC) @(negedge clk);
    end
    keysDown = 16'd0;
    repeat (HOLD) @(negedge clk);
    testsRun++;
    if (digit_count !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL glitch_reject: count %0d, expected 0", digit_count);
    end
    pressKey(K5);
    testsRun++;
    if (input_value !== 32'd5 || digit_count !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL debounced_5: value %0d count %0d, expected 5 1", input_value, digit_count);
    end
    pressMask((16'd1 << K1) | (16'd1 << K2));
    keysDown = (16'd1 << K1) | (16'd1 << K2);
    repeat (HOLD) @(negedge clk);
    keysDown = 16'd1 << K2;
    repeat (HOLD) @(negedge clk);
    keysDown = 16'd0;
    repeat (HOLD) @(negedge clk);
    testsRun++;
    if (input_value !== 32'd5 || digit_count !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL chord_reject: value %0d count %0d, expected 5 1", input_value, digit_count);
    end
    input_enable = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort_reentry();
    input_enable = 1'b1;
    repeat (2) @(negedge clk);
    pressKey(K3);
    input_enable = 1'b0;
    repeat (4) @(negedge clk);
    pressKey(K8);
    testsRun++;
    if (input_value !== 32'd3 || digit_count !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL abort_hold: value %0d count %0d, expected 3 1", input_value, digit_count);
    end
    input_enable = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++;
    if (input_value !== 32'd0 || digit_count !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL reentry_clear: value %0d count %0d, expected 0 0", input_value, digit_count);
    end
    pressEnter(32'd0, 4'd0);
    input_enable = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_entry();
    input_enable = 1'b1;
    repeat (2) @(negedge clk);
    pressKey(K1);
    pressKey(K2);
    testsRun++;
    if (input_value !== 32'd12 || digit_count !== 4'd2) begin
      testsFailed++;
      $display("[TB] FAIL pre_reset_12: value %0d count %0d, expected 12 2", input_value, digit_count);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    testsRun++;
    if ({row_out, input_complete, cpu_pause, input_value, digit_count} !==
        {4'b1110, 1'b0, 1'b0, 32'd0, 4'd0}) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset: row %b cmp %b pause %b value %0d count %0d, expected 1110 0 0 0 0",
               row_out, input_complete, cpu_pause, input_value, digit_count);
    end
    repeat (2) @(negedge clk);
    pressKey(K6);
    pressEnter(32'd6, 4'd1);
    input_enable = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_digit_entry();
    test_overflow_clear();
    test_pause();
    test_debounce();
    test_abort_reentry();
    test_reset_mid_entry();
    testsRun++;
    if (pulsesSeen != pulsesExpected) begin
      testsFailed++;
      $display("[TB] FAIL pulse_total: saw %0d completions, expected %0d", pulsesSeen, pulsesExpected);
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
